// File: rtl/sq_sequencer.sv
// Control sequencer for a run of N back-to-back 5-phase modular squarings.
// Optional stall input `pause` is compiled in when SQ_SEQ_PAUSE_EN is defined.
module sq_sequencer #(
  parameter int ACC_LAT = 3,
  parameter int ITER_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_count,
  input  logic              abort,
`ifdef SQ_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  output logic [4:0]        sq_state,
  output logic              acc_clear,
  output logic              acc_en,
  output logic              op_init,
  output logic              op_load,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iters_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int DW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

  logic [2:0]        state;
  logic [2:0]        phase;
  logic [DW-1:0]     drain_cnt;
  logic [ITER_W-1:0] remaining;
  logic              stall;
  logic              active;

  assign active = (state == S_MUL) || (state == S_DRAIN) || (state == S_WB);

`ifdef SQ_SEQ_PAUSE_EN
  assign stall = pause && active;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      phase      <= 3'd0;
      drain_cnt  <= '0;
      remaining  <= '0;
      iters_done <= '0;
    end else if (abort) begin
      // iters_done is deliberately kept so the host can see how far the run got
      state     <= S_IDLE;
      phase     <= 3'd0;
      drain_cnt <= '0;
      remaining <= '0;
    end else if (!stall) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            iters_done <= '0;
            if (iter_count != '0) begin
              remaining <= iter_count;
              state     <= S_LOAD;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          phase <= 3'd1;
          state <= S_MUL;
        end
        S_MUL: begin
          if (phase == 3'd5) begin
            phase     <= 3'd0;
            drain_cnt <= DW'(ACC_LAT - 1);
            state     <= S_DRAIN;
          end else begin
            phase <= phase + 3'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) state <= S_WB;
          else drain_cnt <= drain_cnt - DW'(1);
        end
        S_WB: begin
          remaining <= remaining - ITER_W'(1);
          if (iters_done != '1) iters_done <= iters_done + ITER_W'(1);
          if (remaining == ITER_W'(1)) begin
            state <= S_DONE;
          end else begin
            phase <= 3'd1;
            state <= S_MUL;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; stall only masks the datapath strobes
  always_comb begin
    sq_state  = (state == S_MUL) ? {2'b00, phase} : 5'd0;
    acc_en    = (state == S_MUL) && !stall;
    acc_clear = (state == S_MUL) && (phase == 3'd1) && !stall;
    op_init   = (state == S_LOAD);
    op_load   = (state == S_WB) && !stall;
    busy      = (state == S_LOAD) || active;
    done      = (state == S_DONE);
  end

endmodule
